// File: rtl/uart_tx_interface_ping_if.sv
// Byte-producer / UART_TX handshake bundle for uart_tx_interface_ping.
// slave = the interface block itself, master = whoever drives it.
interface uart_tx_interface_ping_if;
  logic       wr_en;
  logic [7:0] data_in;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_done_tick;
  logic       busy;
  logic       eot_req;
  logic       eot_sent;

  modport slave (
    input  wr_en, data_in, tx_done_tick, eot_req,
    output full, empty, overflow, tx_start, tx_data, busy, eot_sent
  );

  modport master (
    output wr_en, data_in, tx_done_tick, eot_req,
    input  full, empty, overflow, tx_start, tx_data, busy, eot_sent
  );
endinterface

// File: rtl/uart_tx_interface_ping.sv
// Byte FIFO in front of UART_TX: one tx_start pulse per byte, next launch after tx_done_tick.
// Optional TX_EOT_APPEND_EN: append EOT (8'd4) once the FIFO drains after eot_req.
module uart_tx_interface_ping #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  uart_tx_interface_ping_if.slave  bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {IDLE, WAIT_DONE} state_t;

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  state_t                state_q, state_d;
  logic                  tx_start_q, tx_start_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  overflow_q, overflow_d;
  logic                  push, pop;
  logic                  full_w, empty_w;

  assign full_w  = (count_q == (DEPTH_LOG2+1)'(DEPTH));
  assign empty_w = (count_q == '0);

  assign bus.full     = full_w;
  assign bus.empty    = empty_w;
  assign bus.overflow = overflow_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.busy     = (state_q != IDLE);

`ifdef TX_EOT_APPEND_EN
  logic eot_pending_q, eot_pending_d;
  logic eot_inflight_q, eot_inflight_d;
  logic eot_sent_q, eot_sent_d;
  assign bus.eot_sent = eot_sent_q;
`else
  logic unused_eot_req;
  assign unused_eot_req = bus.eot_req;
  assign bus.eot_sent   = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    pop        = 1'b0;
    // Full rejects a write even when a pop happens in the same cycle.
    push       = bus.wr_en && !full_w;
    overflow_d = overflow_q | (bus.wr_en && full_w);
`ifdef TX_EOT_APPEND_EN
    eot_pending_d  = eot_pending_q | bus.eot_req;
    eot_inflight_d = eot_inflight_q;
    eot_sent_d     = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (!empty_w) begin
          pop        = 1'b1;
          tx_data_d  = mem_q[rd_ptr_q];
          tx_start_d = 1'b1;
          state_d    = WAIT_DONE;
        end
`ifdef TX_EOT_APPEND_EN
        else if (eot_pending_q) begin
          tx_data_d      = 8'd4;
          tx_start_d     = 1'b1;
          state_d        = WAIT_DONE;
          eot_pending_d  = 1'b0;
          eot_inflight_d = 1'b1;
        end
`endif
      end
      WAIT_DONE: begin
        if (bus.tx_done_tick) begin
          state_d = IDLE;
`ifdef TX_EOT_APPEND_EN
          if (eot_inflight_q) begin
            eot_sent_d     = 1'b1;
            eot_inflight_d = 1'b0;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (DEPTH_LOG2+1)'(1);
      2'b01:   count_d = count_q - (DEPTH_LOG2+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'd0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef TX_EOT_APPEND_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      eot_pending_q  <= 1'b0;
      eot_inflight_q <= 1'b0;
      eot_sent_q     <= 1'b0;
    end else begin
      eot_pending_q  <= eot_pending_d;
      eot_inflight_q <= eot_inflight_d;
      eot_sent_q     <= eot_sent_d;
    end
  end
`endif

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.data_in;
  end
endmodule

// File: tb/tb_uart_tx_interface_ping.sv
// Directed bench: scoreboard of expected UART_TX bytes plus an auto done-tick responder.
module tb_uart_tx_interface_ping;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_interface_ping_if bus();
  uart_tx_interface_ping #(.DEPTH_LOG2(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] sb [$];
  int         starts = 0;
  int         eot_cnt = 0;
  int         eot_cyc = -1;
  int         last_done_cyc = -100;
  bit         stall = 1'b0;
  bit         gap_chk = 1'b0;
  logic [7:0] cur_byte = 8'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: every launch pops the scoreboard; tx_data must hold while busy.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.tx_start) begin
        starts++;
        chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) chk("tx_data_order", 32'(bus.tx_data), 32'(sb.pop_front()));
        if (gap_chk) chk("done_to_start", 32'(cyc - last_done_cyc), 32'd2);
        cur_byte = bus.tx_data;
      end else if (bus.busy) begin
        chk("tx_data_hold", 32'(bus.tx_data), 32'(cur_byte));
      end
      if (bus.eot_sent) begin
        eot_cnt++;
        eot_cyc = cyc;
      end
    end
  end

  // Responder: done tick 8 cycles after each tx_start, held off while stall=1.
  initial begin
    bus.tx_done_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && bus.tx_start) begin
        repeat (8) @(posedge clk);
        while (stall) @(posedge clk);
        #1 bus.tx_done_tick = 1'b1;
        last_done_cyc = cyc;
        @(posedge clk);
        #1 bus.tx_done_tick = 1'b0;
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] b, input bit accept);
    bus.wr_en   = 1'b1;
    bus.data_in = b;
    if (accept) sb.push_back(b);
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((sb.size() != 0 || bus.busy || !bus.empty) && n < max) begin
      tick();
      n++;
    end
    chk("drain_in_time", 32'(n < max), 32'd1);
    repeat (3) tick();
  endtask

  initial begin
    int s0;
    rst = 1'b1;
    bus.wr_en = 1'b0;
    bus.data_in = 8'd0;
    bus.eot_req = 1'b0;
    repeat (2) tick();
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_tx_start", 32'(bus.tx_start), 32'd0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    chk("rst_eot_sent", 32'(bus.eot_sent), 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    // Single byte: start at N+2, done at N+10, idle at N+11.
    wr(8'hA5, 1'b1);
    chk("single_n1_start", 32'(bus.tx_start), 32'd0);
    tick();
    chk("single_n2_start", 32'(bus.tx_start), 32'd1);
    chk("single_n2_data", 32'(bus.tx_data), 32'hA5);
    chk("single_n2_busy", 32'(bus.busy), 32'd1);
    tick();
    chk("single_n3_start", 32'(bus.tx_start), 32'd0);
    repeat (7) tick();
    chk("single_n10_busy", 32'(bus.busy), 32'd1);
    tick();
    chk("single_n11_busy", 32'(bus.busy), 32'd0);
    chk("single_n11_empty", 32'(bus.empty), 32'd1);
    repeat (3) tick();

    // Burst order and done-to-start spacing.
    s0 = starts;
    wr(8'h11, 1'b1);
    wr(8'h22, 1'b1);
    wr(8'h33, 1'b1);
    wr(8'h44, 1'b1);
    gap_chk = 1'b1;
    drain(300);
    gap_chk = 1'b0;
    chk("burst_starts", 32'(starts - s0), 32'd4);

    // Overflow: one in flight, four buffered, sixth dropped.
    s0 = starts;
    stall = 1'b1;
    wr(8'h01, 1'b1);
    wr(8'h02, 1'b1);
    wr(8'h03, 1'b1);
    wr(8'h04, 1'b1);
    wr(8'h05, 1'b1);
    chk("ovf_full_before", 32'(bus.full), 32'd1);
    chk("ovf_flag_before", 32'(bus.overflow), 32'd0);
    wr(8'h06, 1'b0);
    chk("ovf_full_after", 32'(bus.full), 32'd1);
    chk("ovf_flag_after", 32'(bus.overflow), 32'd1);
    repeat (5) tick();
    stall = 1'b0;
    drain(400);
    chk("ovf_starts", 32'(starts - s0), 32'd5);
    chk("ovf_sticky", 32'(bus.overflow), 32'd1);

    // Write in the same cycle as a launch: occupancy stays 1.
    s0 = starts;
    wr(8'h5A, 1'b1);
    wr(8'hC3, 1'b1);
    chk("simul_start", 32'(bus.tx_start), 32'd1);
    chk("simul_data", 32'(bus.tx_data), 32'h5A);
    chk("simul_empty", 32'(bus.empty), 32'd0);
    chk("simul_full", 32'(bus.full), 32'd0);
    drain(300);
    chk("simul_starts", 32'(starts - s0), 32'd2);

    // EOT append after FIFO drains.
    s0 = starts;
    wr(8'h41, 1'b1);
    wr(8'h42, 1'b1);
    bus.eot_req = 1'b1;
    tick();
    bus.eot_req = 1'b0;
    wr(8'h43, 1'b1);
`ifdef TX_EOT_APPEND_EN
    sb.push_back(8'h04);
`endif
    drain(400);
    repeat (12) tick();
`ifdef TX_EOT_APPEND_EN
    chk("eot_starts", 32'(starts - s0), 32'd4);
    chk("eot_sent_count", 32'(eot_cnt), 32'd1);
    chk("eot_sent_timing", 32'(eot_cyc - last_done_cyc), 32'd1);
`else
    chk("eot_starts", 32'(starts - s0), 32'd3);
    chk("eot_sent_count", 32'(eot_cnt), 32'd0);
`endif
    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    chk("final_idle", 32'(bus.busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
